// File: rtl/code_conv_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : code_conv_arbiter_if
// Description : Request / result bus for the code-conversion arbiter.
//               slave  modport : the arbiter itself
//               master modport : requesters + downstream consumer side
//   req_valid  [NREQ]        per-requester request valid
//   req_data   [NREQ*WIDTH]  packed words, requester i at [i*WIDTH +: WIDTH]
//   req_mode   [NREQ]        0 = binary-to-Gray, 1 = Gray-to-binary
//   req_ready  [NREQ]        one-hot grant
//   out_valid / out_ready    result handshake
//   out_data   [WIDTH]       converted word
//   out_id     [IDW]         index of the producing requester
//   out_mode                 mode used for out_data
//   conv_count [16]          accepted-conversion counter (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
interface code_conv_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_mode;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;
    logic                  out_mode;
    logic                  out_ready;
    logic [15:0]           conv_count;

    modport slave (
        input  req_valid, req_data, req_mode, out_ready,
        output req_ready, out_valid, out_data, out_id, out_mode, conv_count
    );

    modport master (
        output req_valid, req_data, req_mode, out_ready,
        input  req_ready, out_valid, out_data, out_id, out_mode, conv_count
    );
endinterface
`default_nettype wire

// File: rtl/code_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : code_conv_arbiter
// Description : Round-robin arbiter sharing one binary/Gray conversion
//               datapath among NREQ requesters. One grant per cycle, result
//               held in a single output register with valid/ready handshake.
// Ports       : clk   - rising-edge clock
//               rst_n - synchronous active-low reset
//               bus   - code_conv_arbiter_if.slave (requests, result, count)
// Revision    : 1.0 - initial release
// ============================================================================
module code_conv_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    code_conv_arbiter_if.slave  bus
);

    localparam logic [IDW:0]   c_NREQ = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] c_LAST = IDW'(NREQ - 1);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [IDW-1:0]   out_id_q;
    logic             out_mode_q;
    logic [15:0]      count_q;
    logic [15:0]      count_d;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;

    logic             w_can_accept;
    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_gidx;
    logic             w_any;
    logic [IDW:0]     w_scan;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_mode;
    logic [WIDTH-1:0] w_conv;

    // Rotating-priority scan starting at ptr_q. The scan index is one bit
    // wider than the pointer so the wrap works for non-power-of-two NREQ.
    always_comb begin
        w_can_accept = !out_valid_q || bus.out_ready;
        w_grant      = '0;
        w_gidx       = '0;
        w_any        = 1'b0;
        w_scan       = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = {1'b0, ptr_q} + (IDW+1)'(k);
            if (w_scan >= c_NREQ) begin
                w_scan = w_scan - c_NREQ;
            end
            if (w_can_accept && !w_any && bus.req_valid[w_scan[IDW-1:0]]) begin
                w_grant[w_scan[IDW-1:0]] = 1'b1;
                w_gidx                   = w_scan[IDW-1:0];
                w_any                    = 1'b1;
            end
        end
    end

    // One-hot grant drives a simple AND-OR select of the granted word.
    always_comb begin
        w_sel_data = '0;
        w_sel_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_data = bus.req_data[i*WIDTH +: WIDTH];
                w_sel_mode = bus.req_mode[i];
            end
        end
    end

    // Gray-to-binary bit i is the XOR of all Gray bits at or above i; written
    // as a reduction so there is no combinational self-dependency.
    always_comb begin
        w_conv = '0;
        if (!w_sel_mode) begin
            w_conv = w_sel_data ^ (w_sel_data >> 1);
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                w_conv[i] = ^(w_sel_data >> i);
            end
        end
    end

    always_comb begin
        ptr_d   = (w_gidx == c_LAST) ? '0 : w_gidx + IDW'(1);
        count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_mode_q  <= 1'b0;
            count_q     <= '0;
            ptr_q       <= '0;
        end else if (w_any) begin
            // A grant implies the register is empty or being drained now.
            out_valid_q <= 1'b1;
            out_data_q  <= w_conv;
            out_id_q    <= w_gidx;
            out_mode_q  <= w_sel_mode;
            count_q     <= count_d;
            ptr_q       <= ptr_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_mode   = out_mode_q;
    assign bus.conv_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_code_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_conv_arbiter
// Description : Directed self-checking bench for code_conv_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_conv_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    code_conv_arbiter_if #(.WIDTH(4), .NREQ(4), .IDW(2)) bus ();

    code_conv_arbiter #(.WIDTH(4), .NREQ(4), .IDW(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] gray_tab [16];
    logic [3:0] g;

    initial begin
        gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_mode  = '0;
        bus.out_ready = 1'b0;

        // ---------------- reset state
        do_reset();
        settle();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data",  32'(bus.out_data),  0);
        check("rst_out_id",    32'(bus.out_id),    0);
        check("rst_out_mode",  32'(bus.out_mode),  0);
        check("rst_count",     32'(bus.conv_count), 0);
        check("rst_ready",     32'(bus.req_ready), 0);

        // ---------------- single request, binary-to-Gray
        bus.out_ready     = 1'b1;
        bus.req_valid     = 4'b0001;
        bus.req_data[3:0] = 4'b0100;
        bus.req_mode      = 4'b0000;
        settle();
        check("single_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid = '0;
        check("single_valid", 32'(bus.out_valid), 1);
        check("single_data",  32'(bus.out_data),  32'b0110);
        check("single_id",    32'(bus.out_id),    0);
        check("single_count", 32'(bus.conv_count), 1);

        // ---------------- Gray-to-binary from requester 2 (ptr is 1)
        bus.req_valid     = 4'b0100;
        bus.req_data[11:8] = 4'b1000;
        bus.req_mode      = 4'b0100;
        settle();
        check("g2b_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        check("g2b_data1", 32'(bus.out_data), 32'b1111);
        check("g2b_mode1", 32'(bus.out_mode), 1);
        check("g2b_id1",   32'(bus.out_id),   2);
        bus.req_data[11:8] = 4'b1100;   // still valid, ptr now 3
        tick();
        bus.req_valid = '0;
        check("g2b_data2", 32'(bus.out_data), 32'b1000);
        check("g2b_count", 32'(bus.conv_count), 3);
        tick();
        check("drain_valid", 32'(bus.out_valid), 0);
        check("drain_hold",  32'(bus.out_data), 32'b1000);

        // ---------------- round-robin fairness from ptr 0
        do_reset();
        bus.req_mode  = '0;
        bus.req_data  = {4'd3, 4'd2, 4'd1, 4'd0};
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            settle();
            check("rr_ready", 32'(bus.req_ready), 32'(1 << (n % 4)));
            tick();
            check("rr_id", 32'(bus.out_id), 32'(n % 4));
        end
        check("rr_count", 32'(bus.conv_count), 8);
        // Output now holds requester 3's word: 3 -> Gray 2.

        // ---------------- backpressure with requesters 1 and 3 valid
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1010;
        for (int n = 0; n < 5; n++) begin
            settle();
            check("bp_ready", 32'(bus.req_ready), 0);
            tick();
            check("bp_valid", 32'(bus.out_valid), 1);
            check("bp_id",    32'(bus.out_id),    3);
            check("bp_data",  32'(bus.out_data),  2);
        end
        check("bp_count", 32'(bus.conv_count), 8);
        bus.out_ready = 1'b1;
        settle();
        check("rel_ready1", 32'(bus.req_ready), 32'b0010);
        tick();
        check("rel_id1", 32'(bus.out_id), 1);
        check("rel_data1", 32'(bus.out_data), 1);
        bus.req_valid = 4'b1000;
        settle();
        check("rel_ready2", 32'(bus.req_ready), 32'b1000);
        tick();
        bus.req_valid = '0;
        check("rel_id2", 32'(bus.out_id), 3);
        check("rel_count", 32'(bus.conv_count), 10);

        // ---------------- exhaustive round trip on requester 0
        for (int v = 0; v < 16; v++) begin
            bus.req_valid     = 4'b0001;
            bus.req_mode      = 4'b0000;
            bus.req_data[3:0] = 4'(v);
            tick();
            g = gray_tab[v];
            check("rt_b2g", 32'(bus.out_data), 32'(g));
            bus.req_mode      = 4'b0001;
            bus.req_data[3:0] = bus.out_data;
            tick();
            check("rt_g2b", 32'(bus.out_data), 32'(v));
        end
        bus.req_valid = '0;
        check("rt_count", 32'(bus.conv_count), 42);

        // ---------------- reset while a result is held
        bus.out_ready = 1'b0;
        bus.req_mode  = '0;
        settle();
        check("mid_valid_pre", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_valid", 32'(bus.out_valid), 0);
        check("mid_count", 32'(bus.conv_count), 0);
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b1100;
        settle();
        check("mid_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        check("mid_id", 32'(bus.out_id), 2);

        // ---------------- counter wrap
        do_reset();
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_pre", 32'(bus.conv_count), 32'hFFFF);
        tick();
        check("wrap_zero",  32'(bus.conv_count), 0);
        check("wrap_valid", 32'(bus.out_valid), 1);
        bus.req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
